// File: rtl/leaf_out_stream_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : leaf_pkt_pkg
//  Description : Shared packet layout helpers and port codes for the leaf
//                outbound stream arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package leaf_pkt_pkg;

  // Destination-port codes of control packets arriving from the BFT
  localparam int unsigned CFG_PORT    = 0;
  localparam int unsigned CREDIT_PORT = 1;

  // Width of a user-port index (at least one bit even for a single port)
  function automatic int idx_bits(input int num_ports);
    return (num_ports <= 1) ? 1 : $clog2(num_ports);
  endfunction

  // Width needed to hold 0..init_credits inclusive
  function automatic int credit_bits(input int init_credits);
    return $clog2(init_credits + 1);
  endfunction

  // Packet layout, MSB->LSB: {valid, leaf, port, addr, payload}
  function automatic int packet_bits(input int lb, input int pb, input int ab, input int db);
    return 1 + lb + pb + ab + db;
  endfunction

  function automatic int addr_lsb(input int db);
    return db;
  endfunction

  function automatic int port_lsb(input int ab, input int db);
    return ab + db;
  endfunction

  function automatic int leaf_lsb(input int pb, input int ab, input int db);
    return pb + ab + db;
  endfunction

  function automatic int valid_pos(input int lb, input int pb, input int ab, input int db);
    return lb + pb + ab + db;
  endfunction

endpackage
`default_nettype wire

// File: rtl/leaf_out_stream_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : leaf_out_stream_arbiter_if
//  Description : BFT-side and user-side signal bundle of the outbound leaf
//                arbiter. slave = arbiter, master = its environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface leaf_out_stream_arbiter_if
  import leaf_pkt_pkg::*;
#(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 3,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 9,
  parameter int NUM_OUT_PORTS = 4
);
  localparam int PACKET_BITS = packet_bits(NUM_LEAF_BITS, NUM_PORT_BITS, NUM_ADDR_BITS, PAYLOAD_BITS);

  logic [PACKET_BITS-1:0]                din_leaf_bft2interface;
  logic [PACKET_BITS-1:0]                dout_leaf_interface2bft;
  logic                                  resend;
  logic [PAYLOAD_BITS*NUM_OUT_PORTS-1:0] din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]              ack_interface2user;

  modport slave (
    input  din_leaf_bft2interface,
    input  resend,
    input  din_leaf_user2interface,
    input  vld_user2interface,
    output dout_leaf_interface2bft,
    output ack_interface2user
  );

  modport master (
    output din_leaf_bft2interface,
    output resend,
    output din_leaf_user2interface,
    output vld_user2interface,
    input  dout_leaf_interface2bft,
    input  ack_interface2user
  );
endinterface
`default_nettype wire

// File: rtl/leaf_out_stream_arbiter_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : leaf_out_fifo
//  Description : Small synchronous FIFO with registered occupancy; full and
//                empty are decoded from the occupancy register only.
//  Revision    : 1.0  initial release
// ============================================================================
module leaf_out_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             push_i,
  input  wire logic [WIDTH-1:0] data_i,
  input  wire logic             pop_i,
  output logic      [WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int PTR_BITS = $clog2(DEPTH);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q;
  logic [PTR_BITS-1:0] rd_ptr_q;
  logic [PTR_BITS:0]   count_q;
  logic                do_push;
  logic                do_pop;

  assign full_o  = (count_q == (PTR_BITS+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Storage array: written on accepted push, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/leaf_out_stream_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : leaf_out_stream_arbiter
//  Description : Merges NUM_OUT_PORTS user streams onto one BFT output with
//                per-port destination config, credit flow control,
//                round-robin arbitration and BFT-requested resend.
//  Revision    : 1.0  initial release
// ============================================================================
module leaf_out_stream_arbiter
  import leaf_pkt_pkg::*;
#(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 3,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 9,
  parameter int NUM_OUT_PORTS = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int INIT_CREDITS  = 64
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  leaf_out_stream_arbiter_if.slave   bus
);
  localparam int PACKET_BITS  = packet_bits(NUM_LEAF_BITS, NUM_PORT_BITS, NUM_ADDR_BITS, PAYLOAD_BITS);
  localparam int IDX_BITS     = idx_bits(NUM_OUT_PORTS);
  localparam int CREDIT_BITS  = credit_bits(INIT_CREDITS);
  localparam int ROUTE_BITS   = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int VALID_POS    = valid_pos(NUM_LEAF_BITS, NUM_PORT_BITS, NUM_ADDR_BITS, PAYLOAD_BITS);
  localparam int PORT_LSB     = port_lsb(NUM_ADDR_BITS, PAYLOAD_BITS);
  // The index field takes every payload bit above the low fields, so an index
  // that does not fit IDX_BITS is still recognised as out of range.
  localparam int CFG_IDX_BITS = PAYLOAD_BITS - ROUTE_BITS;
  localparam int CRD_IDX_BITS = PAYLOAD_BITS - CREDIT_BITS;

  // Control packet decode
  logic                     ctrl_vld;
  logic [NUM_PORT_BITS-1:0] ctrl_port;
  logic [CFG_IDX_BITS-1:0]  cfg_idx;
  logic [NUM_LEAF_BITS-1:0] cfg_leaf;
  logic [NUM_PORT_BITS-1:0] cfg_port;
  logic [CRD_IDX_BITS-1:0]  crd_idx;
  logic [CREDIT_BITS-1:0]   crd_inc;

  assign ctrl_vld  = bus.din_leaf_bft2interface[VALID_POS];
  assign ctrl_port = bus.din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS];
  assign cfg_idx   = bus.din_leaf_bft2interface[PAYLOAD_BITS-1:ROUTE_BITS];
  assign cfg_leaf  = bus.din_leaf_bft2interface[NUM_PORT_BITS +: NUM_LEAF_BITS];
  assign cfg_port  = bus.din_leaf_bft2interface[NUM_PORT_BITS-1:0];
  assign crd_idx   = bus.din_leaf_bft2interface[PAYLOAD_BITS-1:CREDIT_BITS];
  assign crd_inc   = bus.din_leaf_bft2interface[CREDIT_BITS-1:0];

  // Per-port state
  logic [NUM_LEAF_BITS-1:0] dest_leaf_q [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dest_port_q [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq_q       [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq_d       [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credits_q   [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credits_d   [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] cfg_q;
  logic [NUM_OUT_PORTS-1:0] cfg_hit;
  logic [NUM_OUT_PORTS-1:0] crd_hit;

  logic [PAYLOAD_BITS-1:0]  head [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] full;
  logic [NUM_OUT_PORTS-1:0] empty;
  logic [NUM_OUT_PORTS-1:0] ack;
  logic [NUM_OUT_PORTS-1:0] elig;
  logic [NUM_OUT_PORTS-1:0] pop;

  logic [IDX_BITS-1:0]      rr_q;
  logic [IDX_BITS-1:0]      grant_idx;
  logic                     grant_vld;
  logic [PACKET_BITS-1:0]   dout_q;

  // Ack uses the registered full flag; gated by reset so it drops immediately
  assign ack                    = bus.vld_user2interface & ~full & {NUM_OUT_PORTS{reset}};
  assign bus.ack_interface2user = ack;
  assign bus.dout_leaf_interface2bft = dout_q;

  for (genvar gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_port
    leaf_out_fifo #(
      .WIDTH (PAYLOAD_BITS),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (ack[gi]),
      .data_i  (bus.din_leaf_user2interface[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .pop_i   (pop[gi]),
      .data_o  (head[gi]),
      .full_o  (full[gi]),
      .empty_o (empty[gi])
    );
  end

  // Round-robin search for the first eligible port starting at the RR pointer
  always_comb begin
    int                  cand;
    logic [IDX_BITS-1:0] cand_idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      elig[i] = ~empty[i] & cfg_q[i] & (credits_q[i] != '0);
    end
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      cand     = (int'(rr_q) + k) % NUM_OUT_PORTS;
      cand_idx = IDX_BITS'(cand);
      if (!grant_vld && elig[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      pop[i] = grant_vld & ~bus.resend & (grant_idx == IDX_BITS'(i));
    end
  end

  // Next credit/sequence values: net credit change saturates, config reloads
  always_comb begin
    int sum;
    sum = 0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      cfg_hit[i] = ctrl_vld && (ctrl_port == NUM_PORT_BITS'(CFG_PORT))
                   && (cfg_idx == CFG_IDX_BITS'(i));
      crd_hit[i] = ctrl_vld && (ctrl_port == NUM_PORT_BITS'(CREDIT_PORT))
                   && (crd_idx == CRD_IDX_BITS'(i));
      sum = int'(credits_q[i]) + (crd_hit[i] ? int'(crd_inc) : 0) - (pop[i] ? 1 : 0);
      if (sum > INIT_CREDITS) sum = INIT_CREDITS;
      credits_d[i] = CREDIT_BITS'(sum);
      seq_d[i]     = seq_q[i] + NUM_ADDR_BITS'(pop[i]);
      if (cfg_hit[i]) begin
        credits_d[i] = CREDIT_BITS'(INIT_CREDITS);
        seq_d[i]     = '0;
      end
    end
  end

  // Per-port destination, configured flag, credit and sequence registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        dest_leaf_q[i] <= '0;
        dest_port_q[i] <= '0;
        seq_q[i]       <= '0;
        credits_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credits_q[i] <= credits_d[i];
        seq_q[i]     <= seq_d[i];
        if (cfg_hit[i]) begin
          cfg_q[i]       <= 1'b1;
          dest_leaf_q[i] <= cfg_leaf;
          dest_port_q[i] <= cfg_port;
        end
      end
    end
  end

  // Output register and RR pointer; resend freezes both
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= '0;
      rr_q   <= '0;
    end else if (!bus.resend) begin
      if (grant_vld) begin
        dout_q <= {1'b1, dest_leaf_q[grant_idx], dest_port_q[grant_idx],
                   seq_q[grant_idx], head[grant_idx]};
        rr_q   <= (grant_idx == IDX_BITS'(NUM_OUT_PORTS-1)) ? '0 : grant_idx + 1'b1;
      end else begin
        dout_q <= '0;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_leaf_out_stream_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_leaf_out_stream_arbiter
//  Description : Self-checking bench: queue-based reference model compared
//                every cycle, directed scenarios with literal expectations,
//                then randomized traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_leaf_out_stream_arbiter;
  localparam int PB = 32, LB = 3, PTB = 4, AB = 9, N = 4, DEPTH = 4, INIT = 64;
  localparam int PKT = 49;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  leaf_out_stream_arbiter_if #(
    .PAYLOAD_BITS(PB), .NUM_LEAF_BITS(LB), .NUM_PORT_BITS(PTB),
    .NUM_ADDR_BITS(AB), .NUM_OUT_PORTS(N)
  ) bus ();

  leaf_out_stream_arbiter #(
    .PAYLOAD_BITS(PB), .NUM_LEAF_BITS(LB), .NUM_PORT_BITS(PTB), .NUM_ADDR_BITS(AB),
    .NUM_OUT_PORTS(N), .FIFO_DEPTH(DEPTH), .INIT_CREDITS(INIT)
  ) dut (
    .clk   (clk),
    .reset (reset_n),
    .bus   (bus)
  );

  int n_vec;
  int n_err;

  // Reference model state
  logic [PB-1:0]  mq [N][$];
  int             m_cred [N];
  int             m_seq  [N];
  bit             m_cfg  [N];
  int             m_dleaf[N];
  int             m_dport[N];
  int             m_rr;
  logic [PKT-1:0] m_dout;
  logic [N-1:0]   m_ack;

  // Stimulus state
  logic [PKT-1:0] st_ctrl;
  logic           st_resend;
  logic           st_rst_n;
  logic [N-1:0]   st_vld;
  logic [N-1:0]   st_stream;
  logic [PB-1:0]  st_data [N];

  logic [PKT-1:0] obs [$];
  int             ack_cnt [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PKT-1:0] mk_pkt(input int leaf, input int port, input int addr,
                                            input logic [PB-1:0] data);
    logic [PKT-1:0] p;
    p = '0;
    p[48]    = 1'b1;
    p[47:45] = leaf[2:0];
    p[44:41] = port[3:0];
    p[40:32] = addr[8:0];
    p[31:0]  = data;
    return p;
  endfunction

  // Control packet; leaf and addr fields carry junk the DUT must ignore
  function automatic logic [PKT-1:0] mk_ctrl(input int port, input logic [PB-1:0] payload);
    logic [PKT-1:0] p;
    logic [31:0]    junk;
    junk = $urandom;
    p = mk_pkt(int'(junk[2:0]), port, int'(junk[12:4]), payload);
    return p;
  endfunction

  function automatic logic [PKT-1:0] cfg_pkt(input int idx, input int leaf, input int port);
    return mk_ctrl(0, (PB'(idx) << 7) | (PB'(leaf & 7) << 4) | PB'(port & 15));
  endfunction

  function automatic logic [PKT-1:0] crd_pkt(input int idx, input int inc);
    return mk_ctrl(1, (PB'(idx) << 7) | PB'(inc & 127));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      m_cred[i] = 0; m_seq[i] = 0; m_cfg[i] = 0; m_dleaf[i] = 0; m_dport[i] = 0;
    end
    m_rr   = 0;
    m_dout = '0;
  endtask

  // One clock edge of the reference model, given the inputs currently applied
  task automatic m_step();
    bit            found;
    int            w;
    int            c;
    int            idx;
    int            port;
    logic [PB-1:0] d;
    logic [PB-1:0] pl;
    found = 0; w = 0;
    if (!st_resend) begin
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (!found && mq[c].size() > 0 && m_cfg[c] && m_cred[c] > 0) begin
          found = 1; w = c;
        end
      end
      if (found) begin
        d         = mq[w].pop_front();
        m_dout    = mk_pkt(m_dleaf[w], m_dport[w], m_seq[w], d);
        m_cred[w] = m_cred[w] - 1;
        m_seq[w]  = (m_seq[w] + 1) % 512;
        m_rr      = (w + 1) % N;
      end else begin
        m_dout = '0;
      end
    end
    for (int i = 0; i < N; i++) if (m_ack[i]) mq[i].push_back(st_data[i]);
    if (st_ctrl[48]) begin
      port = int'(st_ctrl[44:41]);
      pl   = st_ctrl[31:0];
      idx  = int'(pl >> 7);
      if (port == 0 && idx < N) begin
        m_cfg[idx] = 1; m_dleaf[idx] = int'(pl[6:4]); m_dport[idx] = int'(pl[3:0]);
        m_cred[idx] = INIT; m_seq[idx] = 0;
      end else if (port == 1 && idx < N) begin
        m_cred[idx] = m_cred[idx] + int'(pl[6:0]);
        if (m_cred[idx] > INIT) m_cred[idx] = INIT;
      end
    end
  endtask

  // One cycle: check dout, apply inputs, check ack, advance the model
  task automatic cycle();
    @(negedge clk);
    chk("dout", 64'(bus.dout_leaf_interface2bft), 64'(m_dout));
    if (bus.dout_leaf_interface2bft[48]) obs.push_back(bus.dout_leaf_interface2bft);
    reset_n                    = st_rst_n;
    bus.din_leaf_bft2interface = st_ctrl;
    bus.resend                 = st_resend;
    bus.vld_user2interface     = st_vld;
    for (int i = 0; i < N; i++) bus.din_leaf_user2interface[i*PB +: PB] = st_data[i];
    #1;
    for (int i = 0; i < N; i++) m_ack[i] = st_rst_n && st_vld[i] && (mq[i].size() < DEPTH);
    chk("ack", 64'(bus.ack_interface2user), 64'(m_ack));
    for (int i = 0; i < N; i++) ack_cnt[i] += int'(bus.ack_interface2user[i]);
    if (!st_rst_n) m_reset(); else m_step();
    for (int i = 0; i < N; i++) begin
      if (m_ack[i]) begin
        st_data[i] = $urandom;
        if (!st_stream[i]) st_vld[i] = 1'b0;
      end
    end
    st_ctrl = '0;
  endtask

  task automatic do_reset();
    st_rst_n = 0; st_vld = '0; st_stream = '0; st_resend = 0; st_ctrl = '0;
    cycle();
    st_rst_n = 1;
    cycle();
    obs.delete();
  endtask

  task automatic cfg_all();
    for (int i = 0; i < N; i++) begin
      st_ctrl = cfg_pkt(i, i, i + 1);
      cycle();
    end
  endtask

  logic [PKT-1:0] held;
  int             exp_port [8] = '{1, 2, 3, 4, 1, 2, 3, 4};
  int             exp_addr [8] = '{0, 0, 0, 0, 1, 1, 1, 1};

  initial begin
    n_vec = 0; n_err = 0;
    reset_n = 1'b0;
    bus.din_leaf_bft2interface  = '0;
    bus.resend                  = 1'b0;
    bus.din_leaf_user2interface = '0;
    bus.vld_user2interface      = '0;
    st_ctrl = '0; st_resend = 0; st_rst_n = 0; st_stream = '0;
    for (int i = 0; i < N; i++) begin st_data[i] = $urandom; ack_cnt[i] = 0; end
    m_reset();

    // Reset state: all users valid, nothing acked, dout idle
    st_vld = '1;
    repeat (2) cycle();
    chk("reset_dout", 64'(bus.dout_leaf_interface2bft), 64'h0);
    chk("reset_ack", 64'(bus.ack_interface2user), 64'h0);
    do_reset();

    // Config port 2 -> leaf 5/port 9, one word, visible two cycles after ack
    st_ctrl = cfg_pkt(2, 5, 9);
    cycle();
    st_vld[2] = 1'b1; st_data[2] = 32'hA5A5A5A5;
    cycle();
    cycle();
    @(posedge clk); #1;
    chk("t1_dout", 64'(bus.dout_leaf_interface2bft), 64'h1B200A5A5A5A5);

    // All ports streaming: strict round-robin, one packet per cycle
    do_reset();
    cfg_all();
    obs.delete();
    st_stream = '1; st_vld = '1;
    repeat (12) cycle();
    chk("t2_count", 64'(obs.size()), 64'd10);
    for (int k = 0; k < 8; k++) begin
      chk("t2_port", 64'(obs[k][44:41]), 64'(exp_port[k]));
      chk("t2_addr", 64'(obs[k][40:32]), 64'(exp_addr[k]));
    end

    // Credit exhaustion on port 0, then a single credit releases one more word
    do_reset();
    st_ctrl = cfg_pkt(0, 1, 2);
    cycle();
    obs.delete();
    st_stream[0] = 1'b1; st_vld[0] = 1'b1;
    repeat (75) cycle();
    chk("t3_sent", 64'(obs.size()), 64'd64);
    st_ctrl = crd_pkt(0, 1);
    cycle();
    repeat (3) cycle();
    chk("t3_sent_after", 64'(obs.size()), 64'd65);
    chk("t3_addr", 64'(obs[obs.size()-1][40:32]), 64'd64);

    // Resend for three edges mid-stream: dout frozen, FIFOs fill, ack drops
    do_reset();
    cfg_all();
    st_stream = '1; st_vld = '1;
    repeat (8) cycle();
    st_resend = 1;
    cycle();
    held = bus.dout_leaf_interface2bft;
    chk("t4_held_valid", 64'(held[48]), 64'd1);
    cycle();
    chk("t4_hold1", 64'(bus.dout_leaf_interface2bft), 64'(held));
    cycle();
    chk("t4_hold2", 64'(bus.dout_leaf_interface2bft), 64'(held));
    chk("t4_ack_full", 64'(bus.ack_interface2user), 64'h0);
    st_resend = 0;
    cycle();
    chk("t4_hold3", 64'(bus.dout_leaf_interface2bft), 64'(held));
    repeat (10) cycle();

    // Unconfigured port 3: four acks fill its FIFO, nothing is sent
    do_reset();
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    st_stream[3] = 1'b1; st_vld[3] = 1'b1;
    repeat (8) cycle();
    chk("t5_acks", 64'(ack_cnt[3]), 64'd4);
    chk("t5_ack_now", 64'(bus.ack_interface2user), 64'h0);
    st_ctrl = cfg_pkt(7, 1, 1);
    repeat (6) cycle();
    chk("t5_no_out", 64'(obs.size()), 64'd0);

    // Asynchronous reset mid-burst
    do_reset();
    cfg_all();
    st_stream = '1; st_vld = '1;
    repeat (6) cycle();
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("t6_dout_async", 64'(bus.dout_leaf_interface2bft), 64'h0);
    chk("t6_ack_async", 64'(bus.ack_interface2user), 64'h0);
    m_reset();
    st_rst_n = 0;
    cycle();
    st_rst_n = 1;
    obs.delete();
    repeat (8) cycle();
    chk("t6_unconfigured", 64'(obs.size()), 64'd0);

    // Randomized traffic
    do_reset();
    cfg_all();
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom % 16);
      case (r)
        0, 1:    st_ctrl = cfg_pkt(int'($urandom % 6), int'($urandom % 8), int'($urandom % 16));
        2, 3, 4: st_ctrl = crd_pkt(int'($urandom % 5), int'($urandom % 6));
        5:       st_ctrl = crd_pkt(int'($urandom % 4), int'($urandom % 128));
        6:       st_ctrl = mk_ctrl(int'($urandom_range(2, 15)), $urandom);
        7:       begin st_ctrl = cfg_pkt(int'($urandom % 4), 3, 3); st_ctrl[48] = 1'b0; end
        default: st_ctrl = '0;
      endcase
      st_resend = ($urandom % 10 == 0);
      st_rst_n  = ($urandom % 700 != 0);
      for (int i = 0; i < N; i++) begin
        if (!st_vld[i]) begin
          st_vld[i]    = ($urandom % 3 != 0);
          st_stream[i] = ($urandom % 2 == 0);
          st_data[i]   = $urandom;
        end
      end
      cycle();
    end
    st_rst_n = 1; st_resend = 0; st_vld = '0; st_stream = '0;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
